// File: rtl/wave_synth_voice.sv
// wave_synth_voice: single-voice tone generator with selectable waveform, volume and per-channel mute.
// Settings are latched at period boundaries so a running note never glitches.
module wave_synth_voice #(
    parameter int AUDIO_W = 16,
    parameter int DIV_W   = 20,
    parameter int STEP_W  = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [DIV_W-1:0]          note_div,
    input  logic [1:0]                wave_sel,
    input  logic [3:0]                volume,
    input  logic [1:0]                chan_en,
    output logic                      period_start,
    output logic signed [AUDIO_W-1:0] audio_left,
    output logic signed [AUDIO_W-1:0] audio_right
);
    localparam int SL_W = DIV_W - STEP_W;
    localparam int QS   = AUDIO_W - STEP_W;
    localparam logic [AUDIO_W-1:0] A = {1'b0, {(AUDIO_W-1){1'b1}}};
    localparam logic [AUDIO_W-1:0] M = {1'b1, {(AUDIO_W-1){1'b0}}};

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_d;

    logic [SL_W-1:0]           step_len, step_cnt;
    logic [STEP_W-1:0]         phase;
    logic [1:0]                wave_l, chan_l;
    logic [3:0]                vol_l;
    logic                      degen, step_end, load, live_ok, active;
    logic [AUDIO_W-1:0]        ph_ext;
    logic signed [AUDIO_W-1:0] raw, shifted, left_d, right_d;

    always_comb begin
        state_d  = en ? RUN : IDLE;
        degen    = step_len == '0;
        step_end = step_cnt == step_len - 1'b1;
        // entry, wrap, or a degenerate period all re-capture the config
        load     = en && (state == IDLE || degen || (step_end && &phase));
        live_ok  = note_div >= DIV_W'(1 << STEP_W);
        active   = state == RUN && en && !degen && vol_l != 4'd0;
        ph_ext   = AUDIO_W'(phase);
        raw      = wave_l == 2'd1 ? (phase[STEP_W-1] ? -A : A) :
                   wave_l == 2'd2 ? (phase[STEP_W-1] ? A - (AUDIO_W'(phase[STEP_W-2:0]) << (QS+1))
                                                     : M + (ph_ext << (QS+1))) :
                   wave_l == 2'd3 ? M + (ph_ext << QS) : '0;
        shifted  = raw >>> (4'd15 - vol_l);
        left_d   = (active && chan_l[0]) ? shifted : '0;
        right_d  = (active && chan_l[1]) ? shifted : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            step_len     <= '0;
            step_cnt     <= '0;
            phase        <= '0;
            wave_l       <= '0;
            vol_l        <= '0;
            chan_l       <= '0;
            period_start <= 1'b0;
            audio_left   <= '0;
            audio_right  <= '0;
        end else begin
            state        <= state_d;
            period_start <= load && live_ok;
            audio_left   <= left_d;
            audio_right  <= right_d;
            if (!en) begin
                step_cnt <= '0;
                phase    <= '0;
            end else if (load) begin
                step_cnt <= '0;
                phase    <= '0;
                step_len <= note_div[DIV_W-1:STEP_W];
                wave_l   <= wave_sel;
                vol_l    <= volume;
                chan_l   <= chan_en;
            end else if (step_end) begin
                step_cnt <= '0;
                phase    <= phase + 1'b1;
            end else begin
                step_cnt <= step_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_wave_synth_voice.sv
// tb_wave_synth_voice: directed checks of wave_synth_voice waveforms, latching, degenerate div and reset.
module tb_wave_synth_voice;
    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               en = 1'b0;
    logic [19:0]        note_div = '0;
    logic [1:0]         wave_sel = '0;
    logic [3:0]         volume = '0;
    logic [1:0]         chan_en = '0;
    logic               period_start;
    logic signed [15:0] audio_left, audio_right;
    int                 n_vec = 0;
    int                 n_bad = 0;
    int                 k = 0;

    wave_synth_voice dut (
        .clk(clk), .rst_n(rst_n), .en(en), .note_div(note_div), .wave_sel(wave_sel),
        .volume(volume), .chan_en(chan_en), .period_start(period_start),
        .audio_left(audio_left), .audio_right(audio_right)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s at k=%0d: got %0d expected %0d", tag, k, obs, exp);
        end
    endtask

    task automatic go(input int target);
        while (k < target) begin
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("rst_left", audio_left, 0);
        chk("rst_right", audio_right, 0);
        chk("rst_pulse", period_start, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_left", audio_left, 0);
        // square, step_len 100; k counts edges after the entry edge
        note_div = 20'd6400; wave_sel = 2'd1; volume = 4'd15; chan_en = 2'd3; en = 1'b1;
        k = -1;
        go(0);
        chk("entry_pulse", period_start, 1);
        chk("entry_left", audio_left, 0);
        go(1);
        chk("sq_hi_left", audio_left, 32767);
        chk("sq_hi_right", audio_right, 32767);
        chk("pulse_off", period_start, 0);
        go(1000);
        note_div = 20'd1280; wave_sel = 2'd3;
        go(3200);
        chk("sq_hi_end", audio_left, 32767);
        go(3201);
        chk("sq_lo_left", audio_left, -32767);
        chk("sq_lo_right", audio_right, -32767);
        go(6399);
        chk("pre_wrap_pulse", period_start, 0);
        go(6400);
        chk("wrap_pulse", period_start, 1);
        chk("wrap_old_left", audio_left, -32767);
        go(6401);
        chk("saw_p0", audio_left, -32768);
        go(6420);
        chk("saw_p0_held20", audio_left, -32768);
        go(6421);
        chk("saw_p1", audio_left, -31744);
        note_div = 20'd640;
        go(7679);
        chk("p2_pre_pulse", period_start, 0);
        go(7680);
        chk("p2_pulse", period_start, 1);
        go(7691);
        chk("saw10_p1", audio_left, -31744);
        go(8320);
        chk("saw10_p63", audio_left, 31744);
        chk("saw10_pulse", period_start, 1);
        go(8321);
        chk("saw10_wrap", audio_left, -32768);
        go(8400);
        wave_sel = 2'd2; volume = 4'd14; chan_en = 2'd1;
        go(8960);
        chk("tri_still_saw", audio_left, 31744);
        go(8961);
        chk("tri_p0_left", audio_left, -16384);
        chk("tri_p0_right", audio_right, 0);
        go(9281);
        chk("tri_p32_left", audio_left, 16383);
        chk("tri_p32_right", audio_right, 0);
        go(9300);
        chk("tri_p33_left", audio_left, 15359);
        en = 1'b0;
        go(9301);
        chk("dis_left", audio_left, 0);
        chk("dis_pulse", period_start, 0);
        note_div = 20'd63; wave_sel = 2'd1; volume = 4'd15; chan_en = 2'd3; en = 1'b1;
        go(9302);
        chk("degen_pulse0", period_start, 0);
        go(9305);
        chk("degen_left", audio_left, 0);
        chk("degen_right", audio_right, 0);
        chk("degen_pulse", period_start, 0);
        note_div = 20'd640;
        go(9306);
        chk("valid_pulse", period_start, 1);
        go(9307);
        chk("valid_left", audio_left, 32767);
        go(9357);
        chk("pre_rst_left", audio_left, 32767);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_left", audio_left, 0);
        chk("async_rst_right", audio_right, 0);
        #1 rst_n = 1'b1;
        go(9358);
        chk("restart_pulse", period_start, 1);
        chk("restart_left0", audio_left, 0);
        go(9359);
        chk("restart_left", audio_left, 32767);
        chk("restart_pulse_off", period_start, 0);
        go(9400);
        volume = 4'd0;
        go(9998);
        chk("vol_old_left", audio_left, -32767);
        chk("vol_pulse", period_start, 1);
        go(9999);
        chk("vol0_left", audio_left, 0);
        chk("vol0_right", audio_right, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
